// File: rtl/fifo_wr_frontend.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_wr_frontend : skid buffer, full-gated FIFO write issue, ack-checked replay
// Revision: 1.0
// ----------------------------------------------------------------------------
module fifo_wr_frontend #(
  parameter int W_WIDTH    = 4,
  parameter int DEPTH      = 16,
  parameter int SKID_DEPTH = 2,
  parameter int MAX_RETRY  = 3,
  parameter int CNT_W      = 16
) (
  input  logic                   wr_clk_i,
  input  logic                   a_rst_i,
  input  logic                   en_i,
  input  logic                   flush_i,
  input  logic                   clr_err_i,
  input  logic                   s_valid_i,
  input  logic [W_WIDTH-1:0]     s_data_i,
  output logic                   s_ready_o,
  output logic                   fifo_wr_en_o,
  output logic [W_WIDTH-1:0]     fifo_wdata_o,
  input  logic                   fifo_full_i,
  input  logic                   fifo_wr_ack_i,
  input  logic                   fifo_overflow_i,
  input  logic [$clog2(DEPTH):0] fifo_writeable_count_i,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [CNT_W-1:0]       wr_count_o,
  output logic [CNT_W-1:0]       retry_count_o
);

  localparam int c_PTR_W = $clog2(SKID_DEPTH);
  localparam int c_OCC_W = c_PTR_W + 1;
  localparam int c_RTY_W = $clog2(MAX_RETRY + 2);
  localparam logic [c_OCC_W-1:0] c_SKID_FULL = c_OCC_W'(SKID_DEPTH);
  localparam logic [c_RTY_W-1:0] c_RTY_LIMIT = c_RTY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPLAY = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [W_WIDTH-1:0]   r_mem [SKID_DEPTH];
  logic [c_PTR_W-1:0]   r_head;
  logic [c_PTR_W-1:0]   r_tail;
  logic [c_PTR_W-1:0]   w_head_nxt;
  logic [c_PTR_W-1:0]   w_tail_nxt;
  logic [c_OCC_W-1:0]   r_count;
  logic [c_OCC_W-1:0]   w_count_nxt;
  logic                 r_outstanding;
  logic                 r_s_ready;
  logic [c_RTY_W-1:0]   r_retry;
  logic [W_WIDTH-1:0]   r_replay_data;
  logic [CNT_W-1:0]     r_wr_count;
  logic [CNT_W-1:0]     r_retry_count;
  logic                 w_ackmiss;
  logic                 w_ackok;
  logic                 w_busy;
  logic                 w_wr_en;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_replay_issue;
  logic                 w_unused_writeable;

  assign w_ackmiss = r_outstanding & (~fifo_wr_ack_i | fifo_overflow_i);
  assign w_ackok   = r_outstanding & fifo_wr_ack_i & ~fifo_overflow_i;
  assign w_busy    = (r_count != '0) | r_outstanding | (r_state == ST_REPLAY);
  assign w_push    = s_valid_i & r_s_ready & ~flush_i;

  // Free-slot count is advisory; the full flag alone decides write legality.
  assign w_unused_writeable = ^fifo_writeable_count_i;

  always_comb begin
    w_state_nxt    = r_state;
    w_wr_en        = 1'b0;
    w_pop          = 1'b0;
    w_replay_issue = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en_i) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_ackmiss) begin
          w_state_nxt = ST_REPLAY;
        end else begin
          if ((r_count != '0) && !fifo_full_i) begin
            w_wr_en = 1'b1;
            w_pop   = 1'b1;
          end
          if (!en_i && !w_busy) w_state_nxt = ST_IDLE;
        end
      end
      ST_REPLAY: begin
        // Wait for the previous attempt's ack verdict before re-issuing.
        if (!fifo_full_i && !r_outstanding) begin
          w_wr_en        = 1'b1;
          w_replay_issue = 1'b1;
        end
        if (w_ackmiss && (r_retry == c_RTY_LIMIT)) w_state_nxt = ST_HALT;
        else if (w_ackok)                          w_state_nxt = ST_RUN;
      end
      ST_HALT: begin
        if (clr_err_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (flush_i) begin
      w_head_nxt  = '0;
      w_tail_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      if (w_pop)  w_head_nxt = r_head + c_PTR_W'(1);
      if (w_push) w_tail_nxt = r_tail + c_PTR_W'(1);
      if (w_push && !w_pop)      w_count_nxt = r_count + c_OCC_W'(1);
      else if (w_pop && !w_push) w_count_nxt = r_count - c_OCC_W'(1);
    end
  end

  always_ff @(posedge wr_clk_i or negedge a_rst_i) begin
    if (!a_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge wr_clk_i or negedge a_rst_i) begin
    if (!a_rst_i) begin
      for (int i = 0; i < SKID_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_tail] <= s_data_i;
    end
  end

  always_ff @(posedge wr_clk_i or negedge a_rst_i) begin
    if (!a_rst_i) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_outstanding <= 1'b0;
      r_s_ready     <= 1'b0;
      r_retry       <= '0;
      r_replay_data <= '0;
      r_wr_count    <= '0;
      r_retry_count <= '0;
    end else begin
      r_head        <= w_head_nxt;
      r_tail        <= w_tail_nxt;
      r_count       <= w_count_nxt;
      r_outstanding <= w_wr_en;
      // Registered so ready carries no path from the producer's valid.
      r_s_ready     <= (w_count_nxt != c_SKID_FULL) && (w_state_nxt != ST_HALT);
      if (w_pop) r_replay_data <= r_mem[r_head];
      if ((r_state == ST_HALT) && clr_err_i) r_retry <= '0;
      else if (w_ackok)                      r_retry <= '0;
      else if (w_replay_issue)               r_retry <= r_retry + c_RTY_W'(1);
      if (w_ackok && (r_wr_count != {CNT_W{1'b1}}))
        r_wr_count <= r_wr_count + CNT_W'(1);
      if (w_replay_issue && (r_retry_count != {CNT_W{1'b1}}))
        r_retry_count <= r_retry_count + CNT_W'(1);
    end
  end

  assign s_ready_o     = r_s_ready;
  assign fifo_wr_en_o  = w_wr_en;
  assign fifo_wdata_o  = (r_state == ST_REPLAY) ? r_replay_data : r_mem[r_head];
  assign busy_o        = w_busy;
  assign err_o         = (r_state == ST_HALT);
  assign wr_count_o    = r_wr_count;
  assign retry_count_o = r_retry_count;

endmodule
`default_nettype wire
